dc_sa: RTL and testbench
========================

# dc_sa

Parametrised set-associative, write-back, write-allocate data cache; successor to the fixed-geometry data cache. Sits between the processor load/store port and the shared bus. Configurable sets, ways and block size. Adds a blocking miss FSM with dirty write-back, a word-serial bus burst handshake, round-robin replacement, and snoop invalidate/intervene.

## Interface
- SETS, 64, number of sets (power of 2, ≥2)
- WAYS, 2, associativity (power of 2, 1–8)
- WORDS, 8, 32-bit words per block (power of 2, ≥2)
- clk  in  1  single clock, rising edge
- rstN  in  1  reset; synchronous, active-low
- dataInProcessor  in  32  store data
- addrInProcessor  in  32  byte address (bits [1:0] ignored)
- writeFlagProcessor  in  1  store request
- readFlagProcessor  in  1  load request
- dataOutProcessor  out  32  load data
- missFlagProcessor  out  1  request not yet satisfied; processor holds request stable
- dataInBus  in  32  fill data
- addrOutBus  out  32  burst word address
- dataOutBus  out  32  write-back data
- writeOutBus  out  1  1 = write-back burst, 0 = fill burst
- requestOutBus  out  1  bus request
- grantInBus  in  1  bus grant; one word moves per granted cycle
- addrInSnooping  in  32  snooped address
- masterFlagSnooping  in  1  this cache is the bus master
- invalidateFlagIn  in  1  another master invalidates addrInSnooping
- invalidateFlagOut  out  1  this cache requests invalidation of others' copies
- interveneFlagOut  out  1  snooped address hits a dirty line here

## Operation
- Address split: [1:0] byte, next log2(WORDS) word, next log2(SETS) index, rest tag.
- Per line: valid, dirty, tag, WORDS data words. Per set: round-robin victim pointer of log2(WAYS) bits.
- Hit: valid && tag match in any way. Load hit returns word combinationally. Store hit writes word and sets dirty at the edge.
- invalidateFlagOut = 1 in the cycle a store hit commits to a clean line. addrOutBus carries addrInProcessor that cycle.
- Miss FSM states: IDLE → (victim dirty ? WB : FILL) → DONE → IDLE.
- Victim selection: lowest-index invalid way, else the round-robin pointer. Pointer increments (mod WAYS) on each fill.
- WB: requestOutBus=1, writeOutBus=1, addrOutBus={victim tag, index, word, 2'b00}, dataOutBus=victim word. Word counter advances only on grantInBus. After word WORDS-1 → FILL.
- FILL: requestOutBus=1, writeOutBus=0, addrOutBus={tag, index, word, 2'b00}. dataInBus is written into the victim line on each granted cycle. After the last word → DONE.
- DONE: line valid=1, dirty=0. A store miss then merges its word and sets dirty. Return to IDLE, where the request now hits.
- Grant dropping mid-burst pauses the counter. No word is skipped or repeated.
- Snoop: invalidateFlagIn && !masterFlagSnooping && hit on addrInSnooping → valid cleared at the edge. Dirty data is discarded.
- If the snoop matches the block in FILL, the line ends DONE with valid=0. The FSM returns to IDLE and re-misses.
- interveneFlagOut = !masterFlagSnooping && snoop hit on a valid dirty line (combinational).
- Snoop and a processor store hit on the same line in the same cycle: the snoop wins. Line becomes invalid, store is dropped, missFlagProcessor stays 1.

## Timing
- Reset (rstN=0 at edge): all valid/dirty/pointers = 0, FSM IDLE. All outputs 0 next cycle.
- Reset mid-burst aborts: requestOutBus=0 the following cycle; dirty data is lost.
- Hit latency: 0 cycles; missFlagProcessor is combinational.
- Clean miss with continuous grant: missFlagProcessor high for WORDS+2 cycles.
- Dirty miss with continuous grant: missFlagProcessor high for 2·WORDS+2 cycles.
- requestOutBus stays continuously high from the first WB or FILL cycle to the last word. It drops in DONE.
- Simultaneous read and write flags: treated as a write.

## Configuration
- DC_STATS_EN defined: adds outputs hitCount[31:0] and missCount[31:0].
  - Each counts once per request: hit in IDLE, or miss at IDLE→WB/FILL.
  - Counters saturate at 0xFFFFFFFF and reset to 0.
- DC_STATS_EN undefined: the ports and counters do not exist.
- Cache behaviour is identical either way.

## Test plan
- Reset, then load 0x100 → miss: FILL burst at 0x100..0x11C, then a hit returns the bus word for 0x100. missFlagProcessor high 10 cycles (WORDS=8).
- Store 0xDEADBEEF to 0x104 (clean hit) → invalidateFlagOut=1 for one cycle, line dirty. A snoop of 0x104 with master=0 → interveneFlagOut=1.
- Fill all ways of set 0 (WAYS=2), dirty way 0, then miss a third tag → WB burst of 8 words with writeOutBus=1, then FILL. Victim pointer toggles.
- Drop grantInBus on words 3 and 5 of a fill → no word lost or repeated, and completion is delayed by 2 cycles.
- invalidateFlagIn on the block under FILL → line invalid after DONE, and the request re-misses with a second FILL.
- rstN=0 mid-WB → requestOutBus=0 next cycle, and all lines read as misses afterwards.

Source files
------------

// File: rtl/dc_sa.sv
// dc_sa: parametrised set-associative, write-back, write-allocate data cache.
// Blocking miss sequencer (IDLE -> WB -> FILL -> DONE), word-serial bus bursts,
// per-set round-robin replacement, snoop invalidate and intervene.
// Optional build macro DC_STATS_EN adds saturating hitCount/missCount outputs.
module dc_sa #(
  parameter int SETS  = 64,
  parameter int WAYS  = 2,
  parameter int WORDS = 8
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic [31:0] dataInProcessor,
  input  logic [31:0] addrInProcessor,
  input  logic        writeFlagProcessor,
  input  logic        readFlagProcessor,
  output logic [31:0] dataOutProcessor,
  output logic        missFlagProcessor,
  input  logic [31:0] dataInBus,
  output logic [31:0] addrOutBus,
  output logic [31:0] dataOutBus,
  output logic        writeOutBus,
  output logic        requestOutBus,
  input  logic        grantInBus,
  input  logic [31:0] addrInSnooping,
  input  logic        masterFlagSnooping,
  input  logic        invalidateFlagIn,
  output logic        invalidateFlagOut,
  output logic        interveneFlagOut
`ifdef DC_STATS_EN
  ,
  output logic [31:0] hitCount,
  output logic [31:0] missCount
`endif
);

  localparam int WORD_BITS = $clog2(WORDS);
  localparam int IDX_BITS  = $clog2(SETS);
  localparam int WAY_BITS  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAG_BITS  = 32 - 2 - WORD_BITS - IDX_BITS;

  typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

  // Line state
  logic                validMem [SETS][WAYS];
  logic                dirtyMem [SETS][WAYS];
  logic [TAG_BITS-1:0] tagMem   [SETS][WAYS];
  logic [31:0]         dataMem  [SETS][WAYS][WORDS];
  logic [WAY_BITS-1:0] rrPtr    [SETS];

  // Miss sequencer state
  state_t               state;
  logic [WORD_BITS-1:0] beatCnt;
  logic [TAG_BITS-1:0]  missTag;
  logic [IDX_BITS-1:0]  missIdx;
  logic [WAY_BITS-1:0]  victimWay;
  logic                 fillKilled;

  // Address fields
  logic [WORD_BITS-1:0] pWord;
  logic [IDX_BITS-1:0]  pIdx;
  logic [TAG_BITS-1:0]  pTag;
  logic [IDX_BITS-1:0]  sIdx;
  logic [TAG_BITS-1:0]  sTag;
  logic                 unusedAddrBits;

  assign pWord = addrInProcessor[2 +: WORD_BITS];
  assign pIdx  = addrInProcessor[2 + WORD_BITS +: IDX_BITS];
  assign pTag  = addrInProcessor[31 -: TAG_BITS];
  assign sIdx  = addrInSnooping[2 + WORD_BITS +: IDX_BITS];
  assign sTag  = addrInSnooping[31 -: TAG_BITS];
  assign unusedAddrBits = ^{addrInProcessor[1:0], addrInSnooping[WORD_BITS+1:0]};

  // Lookup results
  logic                pHit;
  logic [WAY_BITS-1:0] pHitWay;
  logic                sHit;
  logic [WAY_BITS-1:0] sHitWay;
  logic [WAY_BITS-1:0] victimSel;
  logic                victimFound;

  logic procReq;
  logic snoopKill;
  logic storeClash;
  logic pHitEff;
  logic storeCommit;
  logic missStart;
  logic lastBeat;
  logic snoopFillMatch;
  logic doneMerge;

  // Processor-side tag match across all ways of the indexed set
  always_comb begin
    pHit    = 1'b0;
    pHitWay = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (validMem[pIdx][WAY_BITS'(w)] && tagMem[pIdx][WAY_BITS'(w)] == pTag) begin
        pHit    = 1'b1;
        pHitWay = WAY_BITS'(w);
      end
    end
  end

  // Snoop-side tag match across all ways of the snooped set
  always_comb begin
    sHit    = 1'b0;
    sHitWay = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (validMem[sIdx][WAY_BITS'(w)] && tagMem[sIdx][WAY_BITS'(w)] == sTag) begin
        sHit    = 1'b1;
        sHitWay = WAY_BITS'(w);
      end
    end
  end

  // Victim choice: lowest-index invalid way, otherwise the set's round-robin pointer
  always_comb begin
    victimSel   = rrPtr[pIdx];
    victimFound = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!victimFound && !validMem[pIdx][WAY_BITS'(w)]) begin
        victimSel   = WAY_BITS'(w);
        victimFound = 1'b1;
      end
    end
  end

  assign procReq   = writeFlagProcessor | readFlagProcessor;
  assign snoopKill = invalidateFlagIn && !masterFlagSnooping && sHit;
  // A store racing a snoop invalidate on the same line loses: it is neither
  // committed nor treated as a miss this cycle; next cycle the line is gone.
  assign storeClash  = writeFlagProcessor && snoopKill && pHit &&
                       (sIdx == pIdx) && (sHitWay == pHitWay);
  assign pHitEff     = pHit && !storeClash;
  assign storeCommit = (state == IDLE) && writeFlagProcessor && pHitEff;
  assign missStart   = (state == IDLE) && procReq && !pHit;
  assign lastBeat    = (beatCnt == WORD_BITS'(WORDS - 1));
  assign snoopFillMatch = invalidateFlagIn && !masterFlagSnooping &&
                          (sTag == missTag) && (sIdx == missIdx) &&
                          ((state == FILL) || (state == DONE));
  assign doneMerge   = (state == DONE) && writeFlagProcessor && !(fillKilled || snoopFillMatch);

  // Processor and snoop response flags
  always_comb begin
    dataOutProcessor  = pHit ? dataMem[pIdx][pHitWay][pWord] : '0;
    missFlagProcessor = procReq && !((state == IDLE) && pHitEff);
    invalidateFlagOut = storeCommit && !dirtyMem[pIdx][pHitWay];
    interveneFlagOut  = !masterFlagSnooping && sHit && dirtyMem[sIdx][sHitWay];
  end

  // Bus-side outputs decoded from the sequencer state
  always_comb begin
    addrOutBus    = '0;
    dataOutBus    = '0;
    writeOutBus   = 1'b0;
    requestOutBus = 1'b0;
    case (state)
      IDLE: begin
        if (invalidateFlagOut) addrOutBus = addrInProcessor;
      end
      WB: begin
        requestOutBus = 1'b1;
        writeOutBus   = 1'b1;
        addrOutBus    = {tagMem[missIdx][victimWay], missIdx, beatCnt, 2'b00};
        dataOutBus    = dataMem[missIdx][victimWay][beatCnt];
      end
      FILL: begin
        requestOutBus = 1'b1;
        addrOutBus    = {missTag, missIdx, beatCnt, 2'b00};
      end
      default: begin
      end
    endcase
  end

  // Valid/dirty/tag/replacement state and the miss sequencer
  always_ff @(posedge clk) begin
    if (!rstN) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        rrPtr[IDX_BITS'(s)] <= '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
          validMem[IDX_BITS'(s)][WAY_BITS'(w)] <= 1'b0;
          dirtyMem[IDX_BITS'(s)][WAY_BITS'(w)] <= 1'b0;
        end
      end
      state      <= IDLE;
      beatCnt    <= '0;
      missTag    <= '0;
      missIdx    <= '0;
      victimWay  <= '0;
      fillKilled <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (storeCommit) dirtyMem[pIdx][pHitWay] <= 1'b1;
          if (missStart) begin
            missTag    <= pTag;
            missIdx    <= pIdx;
            victimWay  <= victimSel;
            beatCnt    <= '0;
            fillKilled <= 1'b0;
            if (validMem[pIdx][victimSel] && dirtyMem[pIdx][victimSel]) begin
              state <= WB;
            end else begin
              state                      <= FILL;
              validMem[pIdx][victimSel]  <= 1'b0;
              dirtyMem[pIdx][victimSel]  <= 1'b0;
              tagMem[pIdx][victimSel]    <= pTag;
            end
          end
        end
        WB: begin
          if (grantInBus) begin
            if (lastBeat) begin
              state                          <= FILL;
              beatCnt                        <= '0;
              validMem[missIdx][victimWay]   <= 1'b0;
              dirtyMem[missIdx][victimWay]   <= 1'b0;
              tagMem[missIdx][victimWay]     <= missTag;
            end else begin
              beatCnt <= beatCnt + 1'b1;
            end
          end
        end
        FILL: begin
          if (snoopFillMatch) fillKilled <= 1'b1;
          if (grantInBus) begin
            if (lastBeat) begin
              state   <= DONE;
              beatCnt <= '0;
            end else begin
              beatCnt <= beatCnt + 1'b1;
            end
          end
        end
        DONE: begin
          validMem[missIdx][victimWay] <= !(fillKilled || snoopFillMatch);
          dirtyMem[missIdx][victimWay] <= doneMerge;
          rrPtr[missIdx]               <= (WAYS == 1) ? '0 : rrPtr[missIdx] + 1'b1;
          state                        <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Snoop invalidate last so it overrides any same-cycle update
      if (snoopKill) begin
        validMem[sIdx][sHitWay] <= 1'b0;
        dirtyMem[sIdx][sHitWay] <= 1'b0;
      end
    end
  end

  // Line data: store hits, fill beats and the store-miss merge
  always_ff @(posedge clk) begin
    if (rstN) begin
      if (storeCommit) dataMem[pIdx][pHitWay][pWord] <= dataInProcessor;
      if ((state == FILL) && grantInBus) dataMem[missIdx][victimWay][beatCnt] <= dataInBus;
      if (doneMerge) dataMem[missIdx][victimWay][pWord] <= dataInProcessor;
    end
  end

`ifdef DC_STATS_EN
  logic hitEvent;
  assign hitEvent = (state == IDLE) && procReq && pHitEff;

  // Saturating request statistics
  always_ff @(posedge clk) begin
    if (!rstN) begin
      hitCount  <= '0;
      missCount <= '0;
    end else begin
      if (hitEvent && hitCount != '1) hitCount <= hitCount + 1'b1;
      if (missStart && missCount != '1) missCount <= missCount + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dc_sa.sv
// Self-checking bench for dc_sa (SETS=64, WAYS=2, WORDS=8) with a bus
// responder backed by a reference memory and a scoreboard of expected results.
module tb_dc_sa;
  localparam int SETS  = 64;
  localparam int WAYS  = 2;
  localparam int WORDS = 8;

  logic        clk = 1'b0;
  logic        rstN;
  logic [31:0] dataInProcessor, addrInProcessor;
  logic        writeFlagProcessor, readFlagProcessor;
  logic [31:0] dataOutProcessor;
  logic        missFlagProcessor;
  logic [31:0] dataInBus, addrOutBus, dataOutBus;
  logic        writeOutBus, requestOutBus, grantInBus;
  logic [31:0] addrInSnooping;
  logic        masterFlagSnooping, invalidateFlagIn;
  logic        invalidateFlagOut, interveneFlagOut;
`ifdef DC_STATS_EN
  logic [31:0] hitCount, missCount;
`endif

  always #5 clk = ~clk;

  dc_sa #(.SETS(SETS), .WAYS(WAYS), .WORDS(WORDS)) dut (
    .clk(clk), .rstN(rstN),
    .dataInProcessor(dataInProcessor), .addrInProcessor(addrInProcessor),
    .writeFlagProcessor(writeFlagProcessor), .readFlagProcessor(readFlagProcessor),
    .dataOutProcessor(dataOutProcessor), .missFlagProcessor(missFlagProcessor),
    .dataInBus(dataInBus), .addrOutBus(addrOutBus), .dataOutBus(dataOutBus),
    .writeOutBus(writeOutBus), .requestOutBus(requestOutBus), .grantInBus(grantInBus),
    .addrInSnooping(addrInSnooping), .masterFlagSnooping(masterFlagSnooping),
    .invalidateFlagIn(invalidateFlagIn), .invalidateFlagOut(invalidateFlagOut),
    .interveneFlagOut(interveneFlagOut)
`ifdef DC_STATS_EN
    , .hitCount(hitCount), .missCount(missCount)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Reference memory: bus-side contents and the processor's coherent view
  logic [31:0] busMem   [logic [31:0]];
  logic [31:0] procView [logic [31:0]];

  function automatic logic [31:0] pattern(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] busRead(input logic [31:0] a);
    if (busMem.exists(a)) return busMem[a];
    return pattern(a);
  endfunction

  function automatic logic [31:0] refData(input logic [31:0] a);
    if (procView.exists(a)) return procView[a];
    return busRead(a);
  endfunction

  typedef struct {
    bit          isWr;
    logic [31:0] addr;
    logic [31:0] data;
    int          cycles;
    int          wbBeats;
    int          fillBeats;
    bit          inv;
  } exp_t;
  exp_t sb[$];

  bit dropMask [WORDS];
  int snoopAtBeat = -1;

  // Issue one processor request, serve the bus until it completes, then score it
  task automatic request(input string name, input bit isWr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int cycles, input int wbBeats,
                         input logic [31:0] wbBase, input int fillBeats,
                         input logic [31:0] fillBase, input bit inv);
    exp_t e, got;
    int cyc = 0, wbN = 0, fillN = 0, lastDrop = -1, busErr = 0;
    bit done = 0, snooped = 0;
    logic [31:0] rdData = '0, invAddr = '0;
    logic invSeen = 1'b0;
    e.isWr = isWr; e.addr = addr; e.data = isWr ? wdata : refData(addr);
    e.cycles = cycles; e.wbBeats = wbBeats; e.fillBeats = fillBeats; e.inv = inv;
    sb.push_back(e);
    if (isWr) procView[addr] = wdata;
    addrInProcessor = addr; dataInProcessor = wdata;
    writeFlagProcessor = isWr; readFlagProcessor = !isWr;
    while (!done && cyc < 100) begin
      #1;
      grantInBus = 1'b0; dataInBus = '0;
      if (requestOutBus) begin
        if (!writeOutBus && !snooped && snoopAtBeat >= 0 && fillN == snoopAtBeat) begin
          invalidateFlagIn = 1'b1; masterFlagSnooping = 1'b0;
          addrInSnooping = fillBase; snooped = 1;
        end
        if (writeOutBus) begin
          grantInBus = 1'b1;
          if (addrOutBus !== wbBase + 32'(wbN % WORDS) * 4) busErr++;
          if (dataOutBus !== refData(addrOutBus)) busErr++;
          busMem[addrOutBus] = dataOutBus;
          wbN++;
        end else if (dropMask[fillN % WORDS] && lastDrop != fillN) begin
          lastDrop = fillN;
        end else begin
          grantInBus = 1'b1;
          if (addrOutBus !== fillBase + 32'(fillN % WORDS) * 4) busErr++;
          dataInBus = busRead(addrOutBus);
          fillN++;
        end
      end
      #1;
      if (!missFlagProcessor) begin
        done = 1; rdData = dataOutProcessor;
        invSeen = invalidateFlagOut; invAddr = addrOutBus;
      end else begin
        cyc++;
      end
      @(posedge clk); #1;
      invalidateFlagIn = 1'b0; grantInBus = 1'b0; dataInBus = '0;
    end
    writeFlagProcessor = 1'b0; readFlagProcessor = 1'b0;
    got = sb.pop_front();
    checkVal({name, ".completed"}, 32'(done), 32'd1);
    checkVal({name, ".missCycles"}, cyc, got.cycles);
    checkVal({name, ".wbBeats"}, wbN, got.wbBeats);
    checkVal({name, ".fillBeats"}, fillN, got.fillBeats);
    checkVal({name, ".busErrors"}, busErr, 0);
    if (!got.isWr) checkVal({name, ".loadData"}, rdData, got.data);
    checkVal({name, ".invalidateOut"}, 32'(invSeen), 32'(got.inv));
    if (got.inv) checkVal({name, ".invalidateAddr"}, invAddr, got.addr);
  endtask

  initial begin
    int wbN;
    rstN = 1'b0;
    dataInProcessor = '0; addrInProcessor = '0;
    writeFlagProcessor = 1'b0; readFlagProcessor = 1'b0;
    dataInBus = '0; grantInBus = 1'b0;
    addrInSnooping = '0; masterFlagSnooping = 1'b0; invalidateFlagIn = 1'b0;
    for (int i = 0; i < WORDS; i++) dropMask[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    checkVal("rst.requestOutBus", 32'(requestOutBus), 32'd0);
    checkVal("rst.writeOutBus", 32'(writeOutBus), 32'd0);
    checkVal("rst.addrOutBus", addrOutBus, 32'd0);
    checkVal("rst.dataOutBus", dataOutBus, 32'd0);
    checkVal("rst.missFlag", 32'(missFlagProcessor), 32'd0);
    checkVal("rst.dataOut", dataOutProcessor, 32'd0);
    checkVal("rst.invalidateOut", 32'(invalidateFlagOut), 32'd0);
    checkVal("rst.intervene", 32'(interveneFlagOut), 32'd0);
    rstN = 1'b1;

    // Clean miss then hit
    request("ld100", 0, 32'h100, 0, 10, 0, 0, 8, 32'h100, 0);
    request("hit100", 0, 32'h100, 0, 0, 0, 0, 0, 0, 0);

    // Clean store hit, then snoop intervene
    request("st104", 1, 32'h104, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 1);
    #2;
    checkVal("st104.invOneCycle", 32'(invalidateFlagOut), 32'd0);
    @(posedge clk); #1;
    request("ld104", 0, 32'h104, 0, 0, 0, 0, 0, 0, 0);
    addrInSnooping = 32'h104; masterFlagSnooping = 1'b0;
    #1 checkVal("snoop104.intervene", 32'(interveneFlagOut), 32'd1);
    masterFlagSnooping = 1'b1;
    #1 checkVal("snoop104.master", 32'(interveneFlagOut), 32'd0);
    addrInSnooping = 32'h200; masterFlagSnooping = 1'b0;
    #1 checkVal("snoop200.intervene", 32'(interveneFlagOut), 32'd0);
    @(posedge clk); #1;

    // Set 0: fill both ways, dirty way 0, evict with write-back, pointer rotation
    request("ld0", 0, 32'h0, 0, 10, 0, 0, 8, 32'h0, 0);
    request("ld800", 0, 32'h800, 0, 10, 0, 0, 8, 32'h800, 0);
    request("st8", 1, 32'h8, 32'h1234_5678, 0, 0, 0, 0, 0, 1);
    request("ld1000", 0, 32'h1000, 0, 18, 8, 32'h0, 8, 32'h1000, 0);
    request("hit800", 0, 32'h800, 0, 0, 0, 0, 0, 0, 0);
    request("reld0", 0, 32'h0, 0, 10, 0, 0, 8, 32'h0, 0);
    request("hit1000", 0, 32'h1000, 0, 0, 0, 0, 0, 0, 0);
    request("hit8", 0, 32'h8, 0, 0, 0, 0, 0, 0, 0);
    request("reld800", 0, 32'h800, 0, 10, 0, 0, 8, 32'h800, 0);

    // Grant dropped on fill words 3 and 5
    dropMask[3] = 1; dropMask[5] = 1;
    request("ld4020drop", 0, 32'h4020, 0, 12, 0, 0, 8, 32'h4020, 0);
    dropMask[3] = 0; dropMask[5] = 0;
    request("hit402C", 0, 32'h402C, 0, 0, 0, 0, 0, 0, 0);
    request("hit4034", 0, 32'h4034, 0, 0, 0, 0, 0, 0, 0);

    // Store hit racing a snoop invalidate on the same line
    addrInProcessor = 32'h4024; dataInProcessor = 32'hCAFE_F00D; writeFlagProcessor = 1'b1;
    invalidateFlagIn = 1'b1; addrInSnooping = 32'h4020; masterFlagSnooping = 1'b0;
    #1;
    checkVal("clash.missFlag", 32'(missFlagProcessor), 32'd1);
    checkVal("clash.invalidateOut", 32'(invalidateFlagOut), 32'd0);
    @(posedge clk); #1;
    writeFlagProcessor = 1'b0; invalidateFlagIn = 1'b0;
    request("clashReload", 0, 32'h4024, 0, 10, 0, 0, 8, 32'h4020, 0);

    // Snoop invalidate of the block under fill forces a second fill
    snoopAtBeat = 4;
    request("ld6040snoop", 0, 32'h6040, 0, 20, 0, 0, 16, 32'h6040, 0);
    snoopAtBeat = -1;
    request("hit6044", 0, 32'h6044, 0, 0, 0, 0, 0, 0, 0);

    // Two dirty store misses in set 3, then reset in the middle of a write-back
    request("st7C", 1, 32'h7C, 32'hA1B2_C3D4, 10, 0, 0, 8, 32'h60, 0);
    request("st860", 1, 32'h860, 32'h55AA_55AA, 10, 0, 0, 8, 32'h860, 0);
    addrInProcessor = 32'h1060; readFlagProcessor = 1'b1;
    wbN = 0;
    for (int c = 0; c < 40 && wbN < 3; c++) begin
      #1;
      grantInBus = 1'b0;
      if (requestOutBus && writeOutBus) begin
        grantInBus = 1'b1;
        checkVal("midwb.addr", addrOutBus, 32'h60 + 32'(wbN) * 4);
        busMem[addrOutBus] = dataOutBus;
        wbN++;
      end
      @(posedge clk); #1;
      grantInBus = 1'b0;
    end
    checkVal("midwb.beats", wbN, 3);
    checkVal("midwb.stillWb", 32'(writeOutBus), 32'd1);
    rstN = 1'b0;
    @(posedge clk); #1;
    checkVal("midwb.requestAfterReset", 32'(requestOutBus), 32'd0);
    checkVal("midwb.writeAfterReset", 32'(writeOutBus), 32'd0);
    rstN = 1'b1; readFlagProcessor = 1'b0;
    procView.delete();
    request("post7C", 0, 32'h7C, 0, 10, 0, 0, 8, 32'h60, 0);
    request("post860", 0, 32'h860, 0, 10, 0, 0, 8, 32'h860, 0);
    request("post100", 0, 32'h100, 0, 10, 0, 0, 8, 32'h100, 0);
    request("post104", 0, 32'h104, 0, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
